seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter scan_limit, default 100000, clock cycles each digit stays enabled (legal range 2..2^20).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 value  input  8  unsigned binary count to display (e.g. seconds).
REQ-005 load  input  1  single-cycle strobe; samples value for conversion.
REQ-006 busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-007 digit_en  output  3  one-hot, active-high digit enable; bit0 = units, bit1 = tens, bit2 = hundreds.
REQ-008 seg  output  7  active-high segments, bit0 = a through bit6 = g, for the enabled digit.

Function
REQ-009 The conversion FSM SHALL have states IDLE and CONVERT; IDLE->CONVERT on load, CONVERT->IDLE after 8 iterations.
REQ-010 Conversion SHALL use sequential shift-add-3: one iteration per clock (add 3 to any BCD nibble >=5, then shift left 1), 8 iterations per value.
REQ-011 With load sampled at edge k, busy SHALL be high after edges k..k+7 and low after edge k+8; the converted BCD SHALL be visible on the display registers after edge k+8.
REQ-012 The displayed BCD registers (hundreds, tens, units) SHALL update atomically, only on the final iteration; partial results SHALL never reach seg.
REQ-013 load while busy SHALL latch value into a one-deep pending register (the latest load wins); when the conversion completes with pending set, CONVERT SHALL restart on the next cycle with the pending value and clear pending.
REQ-014 load in the same cycle as the final iteration SHALL be treated as pending (REQ-013) and SHALL NOT be lost.
REQ-015 The scan counter SHALL count 0..scan_limit-1 and wrap; on wrap digit_en SHALL rotate 001->010->100->001.
REQ-016 Scanning SHALL run continuously and independently of busy/load.
REQ-017 seg SHALL be a registered decode of the enabled digit's nibble, updated in the same cycle digit_en changes (no glyph/enable skew).
REQ-018 Digit decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; any other nibble SHALL decode to 0x00.
REQ-019 The BCD result for value 0..255 SHALL be exact (hundreds 0..2).

Reset
REQ-020 On rst_n low, asynchronously: FSM=IDLE, busy=0, pending cleared, BCD registers=0, scan counter=0, digit_en=001, seg=0x3F.
REQ-021 Reset asserted mid-conversion SHALL abort it; display SHALL show 0 and no conversion SHALL resume after release.
REQ-022 After rst_n deasserts, the first load SHALL be honored on the first rising edge.

Configuration
REQ-023 Macro SEG_BLANK_LEADING_ZEROS_EN: when defined, the hundreds digit SHALL output seg=0x00 when it is 0, and the tens digit SHALL output seg=0x00 when both hundreds and tens are 0; units always shown.
REQ-024 Without SEG_BLANK_LEADING_ZEROS_EN all three digits SHALL always show their decoded glyph (leading zeros displayed); the reset value of seg (0x3F) SHALL be the same in both builds.

Verification
REQ-025 scan_limit=4, idle: digit_en sequence 001,010,100,001 with each value held exactly 4 cycles.
REQ-026 load value=20 -> busy high 8 cycles; then units seg=0x3F, tens seg=0x5B, hundreds seg=0x3F (0x00 with macro).
REQ-027 load value=255 -> units 0x6D, tens 0x6D, hundreds 0x5B; load value=0 -> all 0x3F (macro: only units 0x3F, others 0x00).
REQ-028 load 7, then load 9 and load 42 at cycles 3 and 5 of busy -> display shows 7, then after a second 8-cycle busy shows 42; 9 never displayed.
REQ-029 rst_n low during iteration 4 of value 199 -> busy=0, digit_en=001, seg=0x3F immediately; display stays 0 after release.
REQ-030 Self-checking sweep: value 0..255 each loaded and compared against reference model digits; zero mismatches required.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed 7-segment driver with sequential shift-add-3 binary-to-BCD conversion.
// Optional build macro SEG_BLANK_LEADING_ZEROS_EN blanks leading zero digits (hundreds, tens).
module seg_scan_ctrl #(
    parameter int scan_limit = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [2:0] digit_en,
    output logic [6:0] seg
);

    localparam int CW = (scan_limit > 1) ? $clog2(scan_limit) : 1;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic [2:0]  iter_q;
    logic [7:0]  bin_q;
    logic [11:0] work_q;
    logic        pend_q;
    logic [7:0]  pend_val_q;
    logic [3:0]  hund_q, tens_q, units_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  en_q;
    logic [6:0]  seg_q;

    logic [11:0] adj;
    logic [11:0] shifted;
    logic        last_iter;
    logic [3:0]  hund_d, tens_d, units_d;
    logic        wrap;
    logic [2:0]  en_d;
    logic [3:0]  nib;
    logic [6:0]  seg_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // The glyph is computed from next-cycle enable and display values so seg and digit_en change together.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < 3; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        shifted   = {adj[10:0], bin_q[7]};
        last_iter = (state_q == CONVERT) && (iter_q == 3'd7);
        hund_d    = last_iter ? shifted[11:8] : hund_q;
        tens_d    = last_iter ? shifted[7:4]  : tens_q;
        units_d   = last_iter ? shifted[3:0]  : units_q;
        wrap      = (cnt_q == CW'(scan_limit - 1));
        en_d      = wrap ? {en_q[1:0], en_q[2]} : en_q;
        nib       = en_d[2] ? hund_d : (en_d[1] ? tens_d : units_d);
        seg_d     = decode(nib);
`ifdef SEG_BLANK_LEADING_ZEROS_EN
        if (en_d[2] && hund_d == 4'd0) begin
            seg_d = 7'h00;
        end
        if (en_d[1] && hund_d == 4'd0 && tens_d == 4'd0) begin
            seg_d = 7'h00;
        end
`else
`endif
    end

    // A pending request restarts conversion from IDLE one cycle after completion; a fresh load then wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            iter_q     <= 3'd0;
            bin_q      <= 8'd0;
            work_q     <= 12'd0;
            pend_q     <= 1'b0;
            pend_val_q <= 8'd0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            units_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load || pend_q) begin
                        state_q <= CONVERT;
                        busy_q  <= 1'b1;
                        bin_q   <= load ? value : pend_val_q;
                        work_q  <= 12'd0;
                        iter_q  <= 3'd0;
                        pend_q  <= 1'b0;
                    end
                end
                CONVERT: begin
                    bin_q  <= {bin_q[6:0], 1'b0};
                    work_q <= shifted;
                    iter_q <= iter_q + 3'd1;
                    if (load) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= value;
                    end
                    if (last_iter) begin
                        hund_q  <= shifted[11:8];
                        tens_q  <= shifted[7:4];
                        units_q <= shifted[3:0];
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            en_q  <= 3'b001;
            seg_q <= 7'h3F;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
            en_q  <= en_d;
            seg_q <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign digit_en = en_q;
    assign seg      = seg_q;

endmodule
